// File: rtl/key_led_ctrl_multi.sv
// Multi-channel key front end: each raw key pin is synchronised, debounced and
// edge-detected on its own, and drives one LED in follow, toggle or blink-toggle mode.
module key_led_ctrl_multi #(
  parameter int KEY_NUM     = 3,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter bit KEY_ACT_LOW = 1'b1,
  parameter int MODE        = 1,
  parameter int BLINK_HALF  = 25_000_000
) (
  input  logic               m_clk,
  input  logic               m_rst_n,
  input  logic [KEY_NUM-1:0] m_key,
  output logic [KEY_NUM-1:0] m_key_state,
  output logic [KEY_NUM-1:0] m_press_pulse,
  output logic [KEY_NUM-1:0] m_led
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [KEY_NUM-1:0] RELEASED = {KEY_NUM{KEY_ACT_LOW}};
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;
  logic [KEY_NUM-1:0] pressed;
  logic [KEY_NUM-1:0] deb_done;
  logic [KEY_NUM-1:0] toggle_q;
  logic [CW-1:0]      deb_cnt [KEY_NUM];
  logic [BW-1:0]      blink_cnt;
  logic               blink_phase;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= m_key;
      sync2 <= sync1;
    end
  end

  assign pressed = KEY_ACT_LOW ? ~sync2 : sync2;

  always_comb begin
    deb_done = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      deb_done[i] = (pressed[i] != m_key_state[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        deb_cnt[i] <= '0;
      end
      m_key_state   <= '0;
      m_press_pulse <= '0;
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (pressed[i] != m_key_state[i]) begin
          if (deb_done[i]) begin
            m_key_state[i] <= pressed[i];
            deb_cnt[i]     <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
      m_press_pulse <= deb_done & pressed;
    end
  end

  // Shared by toggle mode (LED state) and blink-toggle mode (per-channel blink enable).
  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ (deb_done & pressed);
    end
  end

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    case (MODE)
      0:       m_led = m_key_state;
      1:       m_led = toggle_q;
      default: m_led = toggle_q & {KEY_NUM{blink_phase}};
    endcase
  end

endmodule

// File: tb/tb_key_led_ctrl_multi.sv
// Bench for key_led_ctrl_multi: four instances (follow, toggle, blink, toggle with
// active-high pins) share one key stimulus and are compared to a sample-history model.
module tb_key_led_ctrl_multi;

  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int BH  = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pressed = '0;
  logic [N-1:0] key_lo;
  logic [N-1:0] key_hi;

  logic [N-1:0] st0, pp0, led0;
  logic [N-1:0] st1, pp1, led1;
  logic [N-1:0] st2, pp2, led2;
  logic [N-1:0] st3, pp3, led3;

  logic [15:0]  samp [N];
  logic [N-1:0] m_state;
  logic [N-1:0] m_pulse;
  logic [N-1:0] m_tog;
  int           n_edges;
  int           checks = 0;
  int           failures = 0;

  assign key_lo = ~pressed;
  assign key_hi = pressed;

  always #5 clk = ~clk;

  key_led_ctrl_multi #(.KEY_NUM(N), .DEB_CYCLES(DEB), .KEY_ACT_LOW(1'b1), .MODE(0), .BLINK_HALF(BH)) d0 (
    .m_clk(clk), .m_rst_n(rst_n), .m_key(key_lo), .m_key_state(st0), .m_press_pulse(pp0), .m_led(led0));
  key_led_ctrl_multi #(.KEY_NUM(N), .DEB_CYCLES(DEB), .KEY_ACT_LOW(1'b1), .MODE(1), .BLINK_HALF(BH)) d1 (
    .m_clk(clk), .m_rst_n(rst_n), .m_key(key_lo), .m_key_state(st1), .m_press_pulse(pp1), .m_led(led1));
  key_led_ctrl_multi #(.KEY_NUM(N), .DEB_CYCLES(DEB), .KEY_ACT_LOW(1'b1), .MODE(2), .BLINK_HALF(BH)) d2 (
    .m_clk(clk), .m_rst_n(rst_n), .m_key(key_lo), .m_key_state(st2), .m_press_pulse(pp2), .m_led(led2));
  key_led_ctrl_multi #(.KEY_NUM(N), .DEB_CYCLES(DEB), .KEY_ACT_LOW(1'b0), .MODE(1), .BLINK_HALF(BH)) d3 (
    .m_clk(clk), .m_rst_n(rst_n), .m_key(key_hi), .m_key_state(st3), .m_press_pulse(pp3), .m_led(led3));

  task automatic model_reset();
    for (int c = 0; c < N; c++) samp[c] = '0;
    m_state = '0;
    m_pulse = '0;
    m_tog   = '0;
    n_edges = 0;
  endtask

  // A key flips once the last DEB synchronised samples (two edges old) all disagree with it.
  task automatic model_edge();
    logic all_diff;
    n_edges++;
    m_pulse = '0;
    for (int c = 0; c < N; c++) begin
      samp[c] = {samp[c][14:0], pressed[c]};
      all_diff = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) begin
        if (samp[c][k] == m_state[c]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_state[c] = ~m_state[c];
        if (m_state[c]) begin
          m_pulse[c] = 1'b1;
          m_tog[c]   = ~m_tog[c];
        end
      end
    end
  endtask

  function automatic logic model_phase();
    return ((n_edges / BH) % 2) == 1;
  endfunction

  function automatic logic [36-1:0] exp_vec();
    logic [N-1:0] blink;
    blink = m_tog & {N{model_phase()}};
    return {m_state, m_pulse, m_tog, m_state, m_pulse, blink,
            m_state, m_pulse, m_tog, m_state, m_pulse, m_state};
  endfunction

  function automatic logic [36-1:0] obs_vec();
    return {st3, pp3, led3, st2, pp2, led2, st1, pp1, led1, st0, pp0, led0};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    model_reset();
    repeat (cyc) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pressed = '0;
    model_reset();
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (obs_vec() !== 36'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold t=%0d got=%h exp=0", t, obs_vec());
      end
    end
    rst_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (obs_vec() !== 36'h0) begin
        failures++;
        $display("[TB] FAIL reset_idle t=%0d got=%h exp=0", t, obs_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    logic [8:0] e9;
    pressed[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      e9 = {2'b00, 1'(t >= 6), 2'b00, 1'(t == 6), 2'b00, 1'(t >= 6)};
      checks++;
      if ({st0, pp0, led0} !== e9) begin
        failures++;
        $display("[TB] FAIL press_edge t=%0d got=%h exp=%h", t, {st0, pp0, led0}, e9);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL press_model t=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
    end
    pressed[0] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      e9 = {2'b00, 1'(t < 6), 3'b000, 2'b00, 1'(t < 6)};
      checks++;
      if ({st0, pp0, led0} !== e9) begin
        failures++;
        $display("[TB] FAIL release_edge t=%0d got=%h exp=%h", t, {st0, pp0, led0}, e9);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    int at;
    for (int t = 0; t < 20; t++) begin
      if (t % 2 == 0) pressed[1] = ~pressed[1];
      tick();
      checks++;
      if ({st0[1], pp0[1]} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL bounce_quiet t=%0d got=%b exp=00", t, {st0[1], pp0[1]});
      end
    end
    pressed[1] = 1'b1;
    pulses = 0;
    at = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (pp0[1]) begin
        pulses++;
        at = t;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL bounce_model t=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || at != 6) begin
      failures++;
      $display("[TB] FAIL bounce_pulse got=%0d@%0d exp=1@6", pulses, at);
    end
    pressed[1] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_toggle();
    logic [N-1:0] exp_led [4] = '{3'b100, 3'b100, 3'b000, 3'b000};
    do_reset(3);
    pressed = '0;
    for (int p = 0; p < 4; p++) begin
      pressed[2] = (p % 2 == 0);
      for (int t = 0; t < 8; t++) begin
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("[TB] FAIL toggle_model p=%0d t=%0d got=%h exp=%h", p, t, obs_vec(), exp_vec());
        end
      end
      checks++;
      if ({led1, led3} !== {exp_led[p], exp_led[p]}) begin
        failures++;
        $display("[TB] FAIL toggle_led p=%0d got=%b/%b exp=%b", p, led1, led3, exp_led[p]);
      end
    end
  endtask

  task automatic test_blink();
    int changes;
    logic prev;
    do_reset(2);
    pressed = 3'b001;
    repeat (6) tick();
    checks++;
    if (pp2 !== 3'b001 || led2[0] !== model_phase()) begin
      failures++;
      $display("[TB] FAIL blink_start got=%b/%b exp=001/%b", pp2, led2[0], model_phase());
    end
    changes = 0;
    prev = led2[0];
    for (int t = 0; t < 12; t++) begin
      tick();
      if (led2[0] !== prev) changes++;
      prev = led2[0];
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL blink_model t=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (changes != 4) begin
      failures++;
      $display("[TB] FAIL blink_rate got=%0d exp=4", changes);
    end
    pressed = 3'b000;
    repeat (6) tick();
    pressed = 3'b001;
    repeat (6) tick();
    checks++;
    if (pp2[0] !== 1'b1 || led2[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blink_stop got=%b/%b exp=1/0", pp2[0], led2[0]);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (led2[0] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL blink_off t=%0d got=%b exp=0", t, led2[0]);
      end
    end
    pressed = 3'b000;
    repeat (8) tick();
    pressed = 3'b011;
    repeat (6) tick();
    checks++;
    if (pp2 !== 3'b011) begin
      failures++;
      $display("[TB] FAIL blink_pair_pulse got=%b exp=011", pp2);
    end
    for (int t = 0; t < 9; t++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || led2[0] !== led2[1]) begin
        failures++;
        $display("[TB] FAIL blink_pair t=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
    end
    pressed = 3'b000;
    repeat (8) tick();
  endtask

  task automatic test_async_reset();
    logic [N-1:0] e;
    do_reset(2);
    pressed = 3'b010;
    repeat (8) tick();
    pressed = 3'b011;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 36'h0) begin
      failures++;
      $display("[TB] FAIL async_clear got=%h exp=0", obs_vec());
    end
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      e = (t >= 6) ? 3'b011 : 3'b000;
      checks++;
      if (st0 !== e || st3 !== e || pp0 !== ((t == 6) ? 3'b011 : 3'b000)) begin
        failures++;
        $display("[TB] FAIL async_repress t=%0d got=%b/%b/%b exp=%b", t, st0, st3, pp0, e);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL async_model t=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
      end
    end
    pressed = 3'b000;
    repeat (8) tick();
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 5) == 0) pressed[c] = ~pressed[c];
      end
      if (i == 250) do_reset(2);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_toggle();
    test_blink();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_led_ctrl_multi.md
# key_led_ctrl_multi

Parametrised multi-channel key-to-LED controller: KEY_NUM mechanical key inputs are synchronised, debounced and edge-detected independently, and each channel drives its own LED in one of three modes (follow, toggle, blink-toggle). It replaces the combinational three-key LED logic in the board-level key/LED demo designs and sits directly between the board key pins and the LED pins.

## Interface
- KEY_NUM, 3: number of key/LED channels (1..16).
- DEB_CYCLES, 1_000_000: debounce hold time in clocks (20 ms at 50 MHz); minimum 2; counter width $clog2(DEB_CYCLES).
- KEY_ACT_LOW, 1: 1 = key pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- MODE, 1: 0 = follow, 1 = toggle, 2 = blink-toggle; applies to all channels.
- BLINK_HALF, 25_000_000: blink half-period in clocks (mode 2 only); minimum 1.
- m_clk  in  1  system clock; all logic on the rising edge.
- m_rst_n  in  1  asynchronous active-low reset.
- m_key  in  KEY_NUM  raw, asynchronous key pins; bit i is channel i.
- m_key_state  out  KEY_NUM  debounced state; 1 = pressed, independent of KEY_ACT_LOW.
- m_press_pulse  out  KEY_NUM  one-clock pulse per debounced press (released->pressed).
- m_led  out  KEY_NUM  LED drive, 1 = LED on.

## Operation
- Per channel: 2-FF synchroniser, debounce counter, stable-state register, LED register. No shared state except the blink counter.
- Synchroniser resets to the released pin level (1 if KEY_ACT_LOW, else 0). Polarity is normalised after the synchroniser: pressed = 1.
- Debounce: when the synchronised value differs from the stable state, the counter increments each clock; when it equals DEB_CYCLES-1 and the difference persists, the stable state takes the new value and the counter clears. Whenever they match, the counter clears at once. Any bounce restarts the count.
- Press event: the stable state going 0->1 sets m_press_pulse[i] for exactly one clock. Release (1->0) produces no pulse.
- Mode 0: m_led[i] equals m_key_state[i].
- Mode 1: each press event inverts m_led[i]; releases are ignored.
- Mode 2: each press event inverts an internal blink_en[i]. With blink_en[i]=1, m_led[i] equals the shared blink phase; with blink_en[i]=0, m_led[i]=0.
- Blink counter: free-running 0..BLINK_HALF-1. The phase bit inverts on the clock where the counter wraps, giving a period of 2*BLINK_HALF clocks. All blinking channels stay in phase.
- Simultaneous events on several channels are handled independently in the same clock.

## Timing
- Reset (asynchronous, m_rst_n=0) clears everything immediately: m_key_state=0, m_press_pulse=0, m_led=0, blink_en=0, all counters 0, blink phase 0. These values are held while reset is low.
- Reset mid-debounce or mid-blink aborts the operation. After release, a key already held must complete a full DEB_CYCLES count before it registers.
- Latency: a pin change held stable before rising edge 1 is sampled into sync stage 1 at edge 1 and stage 2 at edge 2. m_key_state updates at edge DEB_CYCLES+2.
- m_press_pulse, the mode-1 LED toggle, the mode-2 blink_en toggle and the mode-0 LED update all happen on the same edge as the m_key_state update. The mode-2 LED first reflects the blink phase in that same cycle.
- A glitch shorter than DEB_CYCLES clocks (in synchronised time) never changes m_key_state.
- Outputs are registered and glitch-free. m_led in mode 2 is the AND of two registers and must not be decoded further off-chip.

## Test plan
- Reset: KEY_NUM=3, m_key=3'b111 (active low), m_rst_n low for 5 clocks -> m_key_state=0, m_press_pulse=0, m_led=0 throughout; all three stay 0 for 20 clocks after release.
- Clean press, DEB_CYCLES=4, MODE=0: drive m_key[0]=0 before edge 1 -> m_key_state[0]=1, m_led[0]=1 and m_press_pulse[0]=1 at edge 6; pulse is 0 at edge 7. Release -> state and LED 0 at edge 6 after release; no pulse.
- Bounce: m_key[1] toggles every 2 clocks for 20 clocks, then stays 0 -> no change during bouncing; exactly one pulse at edge 6 after the last transition.
- Toggle, MODE=1: two separate presses on key 2 -> m_led[2] goes 0->1 on the first press and 1->0 on the second. Releases leave m_led unchanged; the other channels stay 0.
- Blink, MODE=2, BLINK_HALF=3: press key 0 -> m_led[0] follows the phase, toggling every 3 clocks. A second press forces m_led[0]=0 on the pulse edge. Pressing keys 0 and 1 together -> both pulse in the same clock and blink in phase.
- Async reset mid-count: assert m_rst_n low at count 2 of 4 -> outputs clear with no clock. With the key still held after release, the press registers at edge 6 after reset deassertion. Repeat with KEY_ACT_LOW=0 using inverted pin levels.
